sprite_commit_ctrl: RTL and testbench



---
 rtl/sprite_commit_ctrl.sv | 163 ++++++++++++++++
 tb/tb_sprite_commit_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_commit_ctrl.sv
// Sprite object-table commit sequencer: queues per-slot updates, streams a batch into staging on commit,
// sets STAGING_READY, then waits for the vsync swap. Optional macro SPRITE_AUTO_COMMIT_EN.
module sprite_commit_ctrl #(
   parameter int MAX_SPRITES = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int CTRL_ADDR   = 63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_index,
   input  logic [31:0] req_data,
   input  logic        commit,
   input  logic        bitmap_wr_en,
   input  logic        vsync,
   input  logic        user_interrupt,
   output logic [5:0]  spr_address,
   output logic [31:0] spr_data_in,
   output logic [1:0]  spr_write_n,
   output logic        busy,
   output logic        frame_req,
   output logic [4:0]  fifo_count,
   output logic        err_index,
   output logic        commit_ignored
);

   localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_SET_READY,
      S_WAIT_SWAP
   } state_t;

   state_t        state_q, state_d;
   logic [34:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [4:0]    count_q, count_d;
   logic [4:0]    remain_q, remain_d;
   logic          vsync_q;
   logic [5:0]    addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    wn_q, wn_d;
   logic          frame_req_q, commit_ign_q, err_q;
   logic          idx_ok, push, pop, commit_eff;
   logic [34:0]   head;

   assign req_ready = (count_q != DEPTH_C);
   assign idx_ok    = (32'(req_index) < 32'(MAX_SPRITES));
   assign push      = req_valid && req_ready && idx_ok;
   assign head      = mem_q[rd_ptr_q];

`ifdef SPRITE_AUTO_COMMIT_EN
   // A staging request with pending updates commits them; merges with a same-cycle external commit.
   assign commit_eff = commit || (user_interrupt && (count_q != 5'd0));
`else
   assign commit_eff = commit;
`endif

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 5'd1;
      end else if (pop && !push) begin
         count_d = count_q - 5'd1;
      end
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wn_d     = 2'b11;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (commit_eff) begin
               remain_d = count_q;
               state_d  = (count_q == 5'd0) ? S_SET_READY : S_DRAIN;
            end
         end
         S_DRAIN: begin
            pop      = 1'b1;
            addr_d   = {head[34:32], 2'b00};
            data_d   = head[31:0];
            wn_d     = 2'b10;
            remain_d = remain_q - 5'd1;
            if (remain_q == 5'd1) begin
               state_d = S_SET_READY;
            end
         end
         S_SET_READY: begin
            addr_d  = 6'(CTRL_ADDR);
            data_d  = {30'b0, 1'b1, bitmap_wr_en};
            wn_d    = 2'b00;
            state_d = S_WAIT_SWAP;
         end
         S_WAIT_SWAP: begin
            // Only the swap edge seen after READY is set returns control to the host.
            if (vsync && !vsync_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= 5'd0;
         remain_q     <= 5'd0;
         vsync_q      <= 1'b0;
         addr_q       <= 6'd0;
         data_q       <= 32'd0;
         wn_q         <= 2'b11;
         frame_req_q  <= 1'b0;
         commit_ign_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         remain_q     <= remain_d;
         vsync_q      <= vsync;
         addr_q       <= addr_d;
         data_q       <= data_d;
         wn_q         <= wn_d;
         frame_req_q  <= user_interrupt;
         commit_ign_q <= commit && (state_q != S_IDLE);
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         if (req_valid && req_ready && !idx_ok) begin
            err_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {req_index, req_data};
      end
   end

   assign spr_address    = addr_q;
   assign spr_data_in    = data_q;
   assign spr_write_n    = wn_q;
   assign busy           = (state_q != S_IDLE);
   assign frame_req      = frame_req_q;
   assign fifo_count     = count_q;
   assign err_index      = err_q;
   assign commit_ignored = commit_ign_q;

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Bench for sprite_commit_ctrl: directed scenarios then random traffic, all checked cycle by cycle
// against a transaction-timed reference model (queue of pending updates plus commit timestamps).
module tb_sprite_commit_ctrl;

   localparam int MAX_SPRITES = 8;
   localparam int FIFO_DEPTH  = 8;
   localparam int CTRL_ADDR   = 63;

   logic        clk = 1'b0;
   logic        rst, req_valid, commit, bitmap_wr_en, vsync, user_interrupt;
   logic [2:0]  req_index;
   logic [31:0] req_data;
   logic        req_ready, busy, frame_req, err_index, commit_ignored;
   logic [5:0]  spr_address;
   logic [31:0] spr_data_in;
   logic [1:0]  spr_write_n;
   logic [4:0]  fifo_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [34:0] q[$];
   int          cyc = 0;
   bit          busy_m, vprev, err_m, exp_fr, exp_ci, chk_ad;
   int          s_edge, blen;
   logic [1:0]  exp_wn;
   logic [5:0]  exp_addr;
   logic [31:0] exp_data;

   sprite_commit_ctrl #(
      .MAX_SPRITES(MAX_SPRITES),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CTRL_ADDR  (CTRL_ADDR)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_index     (req_index),
      .req_data      (req_data),
      .commit        (commit),
      .bitmap_wr_en  (bitmap_wr_en),
      .vsync         (vsync),
      .user_interrupt(user_interrupt),
      .spr_address   (spr_address),
      .spr_data_in   (spr_data_in),
      .spr_write_n   (spr_write_n),
      .busy          (busy),
      .frame_req     (frame_req),
      .fifo_count    (fifo_count),
      .err_index     (err_index),
      .commit_ignored(commit_ignored)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_update();
      bit          cmt, ready;
      logic [34:0] e;
      cyc++;
      chk_ad = 1'b0;
      if (rst) begin
         q.delete();
         busy_m = 0; vprev = 0; err_m = 0; exp_fr = 0; exp_ci = 0;
         exp_wn = 2'b11; exp_addr = '0; exp_data = '0; chk_ad = 1'b1;
         return;
      end
      cmt = commit;
`ifdef SPRITE_AUTO_COMMIT_EN
      if (!busy_m && user_interrupt && q.size() > 0) cmt = 1;
`endif
      exp_ci = commit && busy_m;
      exp_fr = user_interrupt;
      exp_wn = 2'b11;
      ready  = (q.size() < FIFO_DEPTH);
      if (busy_m) begin
         if (cyc >= s_edge + 1 && cyc <= s_edge + blen) begin
            e = q.pop_front();
            exp_wn = 2'b10; exp_addr = {e[34:32], 2'b00}; exp_data = e[31:0]; chk_ad = 1'b1;
         end else if (cyc == s_edge + blen + 1) begin
            exp_wn = 2'b00; exp_addr = 6'(CTRL_ADDR); exp_data = {30'b0, 1'b1, bitmap_wr_en}; chk_ad = 1'b1;
         end else if (vsync && !vprev) begin
            busy_m = 0;
         end
      end else if (cmt) begin
         busy_m = 1; s_edge = cyc; blen = q.size();
      end
      if (req_valid && ready) begin
         if (int'(req_index) < MAX_SPRITES) q.push_back({req_index, req_data});
         else err_m = 1;
      end
      vprev = vsync;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check("write_n", 32'(spr_write_n), 32'(exp_wn));
      check("busy", 32'(busy), 32'(busy_m));
      check("fifo_count", 32'(fifo_count), q.size());
      check("req_ready", 32'(req_ready), 32'(q.size() < FIFO_DEPTH));
      check("frame_req", 32'(frame_req), 32'(exp_fr));
      check("commit_ignored", 32'(commit_ignored), 32'(exp_ci));
      check("err_index", 32'(err_index), 32'(err_m));
      if (chk_ad) begin
         check("address", 32'(spr_address), 32'(exp_addr));
         check("data", spr_data_in, exp_data);
      end
   endtask

   task automatic idle_in();
      rst = 0; req_valid = 0; commit = 0; user_interrupt = 0;
   endtask

   task automatic do_reset();
      idle_in(); rst = 1; step(); step(); rst = 0;
   endtask

   task automatic push(input logic [2:0] idx, input logic [31:0] d);
      req_valid = 1; req_index = idx; req_data = d; step(); req_valid = 0;
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic vsync_pulse();
      vsync = 1; step(); vsync = 0; step();
   endtask

   initial begin
      idle_in(); vsync = 0; bitmap_wr_en = 0; req_index = 0; req_data = 0;
      do_reset();

      // single entry commit
      push(3'd2, 32'h0F201008);
      commit = 1; step(); commit = 0;
      step();
      check("t1_addr", 32'(spr_address), 32'd8);
      check("t1_data", spr_data_in, 32'h0F201008);
      step();
      check("t1_ctrl_byte", 32'(spr_data_in[7:0]), 32'h02);
      idle_steps(3);
      vsync_pulse();

      // empty commit with bitmap_wr_en set
      bitmap_wr_en = 1;
      commit = 1; step(); commit = 0;
      step();
      check("t2_ctrl_byte", 32'(spr_data_in[7:0]), 32'h03);
      idle_steps(2); vsync_pulse();
      bitmap_wr_en = 0;

      // overfill then drain a full batch
      for (int i = 0; i < 9; i++) push(3'($urandom_range(0, 7)), $urandom);
      check("full_ready", 32'(req_ready), 32'd0);
      check("full_count", 32'(fifo_count), 32'd8);
      commit = 1; step(); commit = 0;
      idle_steps(12); vsync_pulse();

      // commit while busy, push during drain
      push(3'd7, 32'hA5A5_0007);
      commit = 1; step();
      req_valid = 1; req_index = 3'd1; req_data = 32'h1234_5678; step();
      idle_in(); idle_steps(4);
      vsync_pulse();
      do_reset();

      // vsync and reset during drain
      for (int i = 0; i < 3; i++) push(3'(i), $urandom);
      commit = 1; step(); commit = 0;
      vsync = 1; step(); vsync = 0; step();
      rst = 1; step(); rst = 0; idle_steps(2);

      // staging request with two entries queued
      push(3'd4, $urandom); push(3'd5, $urandom);
      user_interrupt = 1; step(); user_interrupt = 0;
      idle_steps(5); vsync_pulse();
      do_reset();

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         rst            = ($urandom_range(0, 499) == 0);
         req_valid      = $urandom_range(0, 1);
         req_index      = 3'($urandom_range(0, 7));
         req_data       = $urandom;
         commit         = ($urandom_range(0, 14) == 0);
         user_interrupt = ($urandom_range(0, 29) == 0);
         bitmap_wr_en   = $urandom_range(0, 1);
         if ($urandom_range(0, 19) == 0) vsync = ~vsync;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
